// File: rtl/crc_ram_pkg.sv
// Shared types and constants for the CRC RAM checker and the packet-side CRC logic.
package crc_ram_pkg;

    localparam int CRC_W = 16;

    localparam logic [CRC_W-1:0] CRC_POLY_DEFAULT = 16'h1021;
    localparam logic [CRC_W-1:0] CRC_INIT_DEFAULT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WB_HI,
        WB_LO,
        DONE
    } state_t;

endpackage

// File: rtl/crc16_byte_update.sv
// Combinational CRC-16 step over one byte, MSB first, no reflection.
module crc16_byte_update
    import crc_ram_pkg::*;
(
    input  logic [CRC_W-1:0] crc_i,
    input  logic [7:0]       data_i,
    input  logic [CRC_W-1:0] poly_i,
    output logic [CRC_W-1:0] crc_o
);

    logic [CRC_W-1:0] work;
    logic             feedback;

    always_comb begin
        work     = crc_i;
        feedback = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            feedback = work[CRC_W-1] ^ data_i[k];
            work     = {work[CRC_W-2:0], 1'b0} ^ (feedback ? poly_i : '0);
        end
        crc_o = work;
    end

endmodule

// File: rtl/crc_ram_checker.sv
// Avalon-MM master computing CRC-16 over a RAM block through the s2 port.
// Define CRC_RAM_CHECKER_WRITEBACK_EN to append the CRC (high byte first) after the block.
module crc_ram_checker
    import crc_ram_pkg::*;
#(
    parameter int               ADDR_W   = 8,
    parameter logic [CRC_W-1:0] CRC_POLY = CRC_POLY_DEFAULT,
    parameter logic [CRC_W-1:0] CRC_INIT = CRC_INIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [CRC_W-1:0]  crc_out,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              write,
    output logic [7:0]        writedata,
    output logic              clken,
    input  logic [7:0]        readdata
);

    localparam logic [ADDR_W:0] CNT_ONE = 1;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  base_q;
    logic [ADDR_W:0]    len_q;
    logic [ADDR_W:0]    cnt_q;
    logic               valid_q;
    logic [CRC_W-1:0]   crc_q;
    logic [CRC_W-1:0]   crc_d;
    logic               lastRead;
    logic               accept;

    crc16_byte_update u_update (
        .crc_i  (crc_q),
        .data_i (readdata),
        .poly_i (CRC_POLY),
        .crc_o  (crc_d)
    );

    assign lastRead = (cnt_q == (len_q - CNT_ONE));
    assign accept   = (state_q == IDLE) && start;
    assign crc_out  = crc_q;
    assign clken    = 1'b1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (length == '0) ? DONE : READ;
            READ:    if (lastRead) state_d = DRAIN;
`ifdef CRC_RAM_CHECKER_WRITEBACK_EN
            DRAIN:   state_d = WB_HI;
`else
            DRAIN:   state_d = DONE;
`endif
            WB_HI:   state_d = WB_LO;
            WB_LO:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus signals decode straight from state so reset drops them on the same edge.
    always_comb begin
        busy       = (state_q == READ) || (state_q == DRAIN) ||
                     (state_q == WB_HI) || (state_q == WB_LO);
        done       = (state_q == DONE);
        address    = '0;
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = 8'h00;
        case (state_q)
            READ: begin
                address    = base_q + cnt_q[ADDR_W-1:0];
                chipselect = 1'b1;
            end
`ifdef CRC_RAM_CHECKER_WRITEBACK_EN
            WB_HI: begin
                address    = base_q + len_q[ADDR_W-1:0];
                chipselect = 1'b1;
                write      = 1'b1;
                writedata  = crc_q[15:8];
            end
            WB_LO: begin
                address    = base_q + len_q[ADDR_W-1:0] + CNT_ONE[ADDR_W-1:0];
                chipselect = 1'b1;
                write      = 1'b1;
                writedata  = crc_q[7:0];
            end
`endif
            default: ;
        endcase
    end

    // valid_q marks the cycle in which the byte addressed last cycle is on readdata.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            crc_q   <= CRC_INIT;
        end else begin
            state_q <= state_d;
            valid_q <= (state_q == READ);
            if (accept) begin
                base_q <= base_addr;
                len_q  <= length;
                cnt_q  <= '0;
                crc_q  <= CRC_INIT;
            end else begin
                if (state_q == READ) cnt_q <= cnt_q + CNT_ONE;
                if (valid_q) crc_q <= crc_d;
            end
        end
    end

endmodule

// File: doc/crc_ram_checker.md
Name: crc_ram_checker

Overview:
- Avalon-MM master that reads a contiguous byte block from the 256x8 dual-port CRC RAM (second slave port) and computes CRC-16 over it.
- Sits between the control logic and the RAM's s2 port; the other side (s1) is filled by the processor or packet writer.
- Returns the CRC with a start/busy/done handshake.
- Optionally writes the CRC back into the RAM directly after the block.

Parameters:
- ADDR_W, 8, RAM address width (depth 2^ADDR_W bytes).
- CRC_POLY, 16'h1021, CRC-16 generator polynomial, MSB-first, no reflection.
- CRC_INIT, 16'hFFFF, CRC register seed; no final XOR.

Ports:
- clk  in  1  single clock; RAM port clocked by the same clk.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  first byte address; latched on accepted start.
- length  in  ADDR_W+1  byte count, 0..256; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when crc_out is final.
- crc_out  out  16  result; held until the next accepted start.
- address  out  ADDR_W  RAM s2 address.
- chipselect  out  1  RAM s2 chipselect.
- write  out  1  RAM s2 write strobe.
- writedata  out  8  RAM s2 write data.
- clken  out  1  RAM s2 clock enable; tied 1.
- readdata  in  8  RAM s2 read data; valid one cycle after the address with chipselect=1, write=0.

Behaviour:
- Reset values:
  - busy=0, done=0, crc_out=CRC_INIT.
  - address=0, chipselect=0, write=0, writedata=0.
  - FSM in IDLE.
- FSM states: IDLE, READ, DRAIN, WB_HI, WB_LO, DONE.
- IDLE:
  - Start is accepted at edge T0.
  - Latch base_addr and length; crc <= CRC_INIT; byte counter <= 0.
  - If length=0, go to DONE; otherwise go to READ.
- READ:
  - In cycle T0+1+i, drive address=base+i (mod 2^ADDR_W), chipselect=1, write=0.
  - After the address for byte length-1 is issued, go to DRAIN.
- Read pipeline:
  - The read issued in cycle c returns in cycle c+1.
  - A one-bit valid register tracks outstanding reads.
  - On each valid cycle, crc <= next_crc(crc, readdata).
  - Exactly one update per byte; no stalls.
- DRAIN:
  - chipselect=0; consume the final byte.
  - Then go to WB_HI if the write-back feature is compiled in, else DONE.
- DONE:
  - done=1 for exactly one cycle; busy drops in the same cycle; return to IDLE.
- Latency without write-back: done is high in cycle T0+length+2. For length=0, done is high in cycle T0+1 and crc_out=CRC_INIT.
- CRC arithmetic:
  - 8 iterations per byte, MSB of data first.
  - fb = crc[15] ^ d[7-k]; crc = {crc[14:0],1'b0} ^ (fb ? CRC_POLY : 0).
- Wrap-around: addresses are modulo 2^ADDR_W. length=256 reads every byte once, starting at base_addr.
- start while busy: ignored; no queueing.
- start in the same cycle as done: ignored; the next start is accepted from IDLE.
- Reset mid-operation: same-edge return to IDLE with reset values. Any in-flight readdata is discarded and any partial write is abandoned.
- readdata is ignored whenever the valid register is 0.

Optional Feature:
- Macro: CRC_RAM_CHECKER_WRITEBACK_EN.
- Defined:
  - After DRAIN, WB_HI writes crc[15:8] at base+length and WB_LO writes crc[7:0] at base+length+1, both modulo 2^ADDR_W.
  - Each write is one cycle with chipselect=1, write=1.
  - done is then high in cycle T0+length+4.
  - Write-back may overwrite the first block bytes when length>=255. This is allowed and not checked.
- Undefined: WB states are unreachable, write is tied 0, writedata is tied 0.

Decomposition:
- Package crc_ram_pkg holds:
  - state enum (IDLE, READ, DRAIN, WB_HI, WB_LO, DONE);
  - CRC_W=16;
  - default CRC_POLY and CRC_INIT constants.
- Sub-module crc16_byte_update: combinational, inputs crc[15:0], data[7:0], poly; output next crc. It is reusable by the packet-side CRC.

Test Plan:
- Preload "123456789" (0x31..0x39) at addr 0x10; start with base=0x10, length=9 -> done in cycle T0+11, crc_out=0x29B1, busy high for 10 cycles.
- base=0xFE, length=4 over bytes 0xAA,0x55,0x00,0xFF -> addresses 0xFE,0xFF,0x00,0x01 in consecutive cycles; crc_out equals the reference model.
- length=0 -> done at T0+1, crc_out=0xFFFF, chipselect never asserted.
- Extra start pulses during busy, and a start in the same cycle as done -> no effect; a later start from IDLE proceeds normally.
- reset asserted at byte 3 of length 9 -> next edge: chipselect=0, busy=0, crc_out=0xFFFF; a fresh 9-byte run then gives 0x29B1.
- With CRC_RAM_CHECKER_WRITEBACK_EN, the "123456789" case -> RAM[0x19]=0x29, RAM[0x1A]=0xB1, done at T0+13; without the macro, write stays 0 throughout.
